// File: rtl/li_pkg.sv
// rtl/li_pkg.sv - opcodes, state/class enums and I-type encoder for the load-immediate expander
package li_pkg;

    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_LUI   = 6'b001111;

    typedef enum logic [1:0] {
        IDLE,
        EMIT1,
        EMIT2
    } li_state_e;

    // SEXT/ZEXT/UPPER fit in one word; PAIR needs lui followed by ori
    typedef enum logic [1:0] {
        SEXT,
        ZEXT,
        UPPER,
        PAIR
    } li_class_e;

    function automatic logic [31:0] li_encode(
        input logic [5:0]  opc,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm
    );
        return {opc, rs, rt, imm};
    endfunction

    // First word of any sequence always reads $0 as its source
    function automatic logic [31:0] li_first_word(
        input li_class_e   cls,
        input logic [31:0] value,
        input logic [4:0]  rt
    );
        case (cls)
            SEXT:    return li_encode(OPC_ADDIU, 5'd0, rt, value[15:0]);
            ZEXT:    return li_encode(OPC_ORI,   5'd0, rt, value[15:0]);
            default: return li_encode(OPC_LUI,   5'd0, rt, value[31:16]);
        endcase
    endfunction

endpackage

// File: rtl/li_expander_if.sv
// rtl/li_expander_if.sv - request/instruction handshake bundle for the load-immediate expander
interface li_expander_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic [4:0]  in_rt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;

    modport master (
        output in_valid,
        input  in_ready,
        output in_value,
        output in_rt,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_last
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_value,
        input  in_rt,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_last
    );

endinterface

// File: rtl/li_classify.sv
// rtl/li_classify.sv - picks the shortest immediate sequence class for a 32-bit constant
module li_classify
    import li_pkg::*;
#(
    parameter bit ALLOW_ADDIU = 1'b1
) (
    input  logic [31:0] i_value,
    output li_class_e   o_class
);

    logic w_sext_fits;
    logic w_upper_zero;
    logic w_lower_zero;

    assign w_sext_fits  = (&i_value[31:15]) | (~|i_value[31:15]);
    assign w_upper_zero = ~|i_value[31:16];
    assign w_lower_zero = ~|i_value[15:0];

    // Priority: addiu, then ori, then lui, else the two-word pair
    always_comb begin
        o_class = PAIR;
        if (ALLOW_ADDIU && w_sext_fits) begin
            o_class = SEXT;
        end else if (w_upper_zero) begin
            o_class = ZEXT;
        end else if (w_lower_zero) begin
            o_class = UPPER;
        end
    end

endmodule

// File: rtl/li_expander.sv
// rtl/li_expander.sv - load-immediate expander top; optional LI_ZERO_DROP_EN swallows requests targeting $0
module li_expander
    import li_pkg::*;
#(
    parameter bit ALLOW_ADDIU = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    li_expander_if.slave bus
);

    li_state_e   r_state;
    li_class_e   r_class;
    logic [15:0] r_imm_lo;
    logic [4:0]  r_rt;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        r_out_last;
    logic [31:0] r_out_instr;

    li_class_e   w_class;
    logic [31:0] w_first;
    logic [31:0] w_second;
    logic        w_accept;
    logic        w_out_fire;
    logic        w_drop;

    li_classify #(
        .ALLOW_ADDIU(ALLOW_ADDIU)
    ) u_classify (
        .i_value(bus.in_value),
        .o_class(w_class)
    );

    assign w_accept   = bus.in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & bus.out_ready;

    // The first word is built straight from the request so it is ready the cycle after accept;
    // only the low half of the value is still needed afterwards, for the PAIR ori word.
    assign w_first  = li_first_word(w_class, bus.in_value, bus.in_rt);
    assign w_second = li_encode(OPC_ORI, r_rt, r_rt, r_imm_lo);

`ifdef LI_ZERO_DROP_EN
    assign w_drop = (bus.in_rt == 5'd0);
`else
    assign w_drop = 1'b0;
`endif

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_instr = r_out_instr;
    assign bus.out_last  = r_out_last;

    // Sequencer: accept in IDLE, present one or two words, hold them stable until taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_class     <= SEXT;
            r_imm_lo    <= 16'd0;
            r_rt        <= 5'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_instr <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept && !w_drop) begin
                        r_imm_lo    <= bus.in_value[15:0];
                        r_rt        <= bus.in_rt;
                        r_class     <= w_class;
                        r_out_instr <= w_first;
                        r_out_last  <= (w_class != PAIR);
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b0;
                        r_state     <= EMIT1;
                    end
                end
                EMIT1: begin
                    if (w_out_fire) begin
                        if (r_class == PAIR) begin
                            r_out_instr <= w_second;
                            r_out_last  <= 1'b1;
                            r_state     <= EMIT2;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_state     <= IDLE;
                        end
                    end
                end
                EMIT2: begin
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_li_expander.sv
// tb/tb_li_expander.sv - directed vector bench for li_expander (both ALLOW_ADDIU settings)
module tb_li_expander;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        d_in_valid;
    logic [31:0] d_in_value;
    logic [4:0]  d_in_rt;
    logic        d_out_ready;

    logic        m_in_ready;
    logic        m_out_valid;
    logic [31:0] m_out_instr;
    logic        m_out_last;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    li_expander_if bus_a ();
    li_expander_if bus_b ();

    assign bus_a.in_valid  = d_in_valid & ~sel;
    assign bus_a.in_value  = d_in_value;
    assign bus_a.in_rt     = d_in_rt;
    assign bus_a.out_ready = d_out_ready & ~sel;

    assign bus_b.in_valid  = d_in_valid & sel;
    assign bus_b.in_value  = d_in_value;
    assign bus_b.in_rt     = d_in_rt;
    assign bus_b.out_ready = d_out_ready & sel;

    assign m_in_ready  = sel ? bus_b.in_ready  : bus_a.in_ready;
    assign m_out_valid = sel ? bus_b.out_valid : bus_a.out_valid;
    assign m_out_instr = sel ? bus_b.out_instr : bus_a.out_instr;
    assign m_out_last  = sel ? bus_b.out_last  : bus_a.out_last;

    li_expander #(.ALLOW_ADDIU(1'b1)) u_dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_a)
    );

    li_expander #(.ALLOW_ADDIU(1'b0)) u_dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_b)
    );

    typedef struct {
        logic        sel;
        logic [31:0] value;
        logic [4:0]  rt;
        int          stall;
        logic        pair;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic [31:0] v, input logic [4:0] rt,
                                input int stall, input logic pair,
                                input logic [31:0] w0, input logic [31:0] w1);
        vec_t t;
        t.sel = s; t.value = v; t.rt = rt; t.stall = stall;
        t.pair = pair; t.w0 = w0; t.w1 = w1;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int k = 0;
        while (m_in_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_in_ready_wait"}, {31'd0, m_in_ready}, 32'd1);
    endtask

    task automatic send(input string name, input logic [31:0] v, input logic [4:0] rt);
        wait_ready(name);
        d_in_valid = 1'b1;
        d_in_value = v;
        d_in_rt    = rt;
        @(negedge clk);
        d_in_valid = 1'b0;
        d_in_value = ~v;
        d_in_rt    = ~rt;
    endtask

    task automatic expect_word(input string name, input logic [31:0] w, input logic last,
                               input int stall);
        chk({name, "_valid"}, {31'd0, m_out_valid}, 32'd1);
        chk({name, "_instr"}, m_out_instr, w);
        chk({name, "_last"}, {31'd0, m_out_last}, {31'd0, last});
        chk({name, "_in_ready"}, {31'd0, m_in_ready}, 32'd0);
        d_out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({name, "_stall_valid"}, {31'd0, m_out_valid}, 32'd1);
            chk({name, "_stall_instr"}, m_out_instr, w);
            chk({name, "_stall_last"}, {31'd0, m_out_last}, {31'd0, last});
            chk({name, "_stall_in_ready"}, {31'd0, m_in_ready}, 32'd0);
        end
        d_out_ready = 1'b1;
        @(negedge clk);
        d_out_ready = 1'b0;
    endtask

    task automatic expect_idle(input string name);
        chk({name, "_idle_valid"}, {31'd0, m_out_valid}, 32'd0);
        chk({name, "_idle_in_ready"}, {31'd0, m_in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs.push_back(mk(1'b0, 32'hFFFF_FFFC, 5'd5,  0, 1'b0, 32'h2405FFFC, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0000_8000, 5'd3,  0, 1'b0, 32'h34038000, 32'h0));
        vecs.push_back(mk(1'b0, 32'h1234_0000, 5'd8,  0, 1'b0, 32'h3C081234, 32'h0));
        vecs.push_back(mk(1'b0, 32'hDEAD_BEEF, 5'd9,  3, 1'b1, 32'h3C09DEAD, 32'h3529BEEF));
        vecs.push_back(mk(1'b0, 32'h0000_7FFF, 5'd31, 0, 1'b0, 32'h241F7FFF, 32'h0));
        vecs.push_back(mk(1'b0, 32'hFFFF_8000, 5'd2,  1, 1'b0, 32'h24028000, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0000_FFFF, 5'd4,  0, 1'b0, 32'h3404FFFF, 32'h0));
        vecs.push_back(mk(1'b0, 32'hFFFF_0000, 5'd6,  0, 1'b0, 32'h3C06FFFF, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0000_0000, 5'd7,  0, 1'b0, 32'h24070000, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0001_0001, 5'd10, 0, 1'b1, 32'h3C0A0001, 32'h354A0001));
        vecs.push_back(mk(1'b0, 32'h8000_0000, 5'd12, 0, 1'b0, 32'h3C0C8000, 32'h0));
        vecs.push_back(mk(1'b1, 32'h0000_0005, 5'd3,  0, 1'b0, 32'h34030005, 32'h0));
        vecs.push_back(mk(1'b1, 32'hFFFF_8000, 5'd2,  2, 1'b1, 32'h3C02FFFF, 32'h34428000));
`ifndef LI_ZERO_DROP_EN
        vecs.push_back(mk(1'b0, 32'hDEAD_BEEF, 5'd0,  0, 1'b1, 32'h3C00DEAD, 32'h3400BEEF));
`endif

        sel         = 1'b0;
        d_in_valid  = 1'b0;
        d_in_value  = 32'd0;
        d_in_rt     = 5'd0;
        d_out_ready = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);

        for (int d = 0; d < 2; d++) begin
            sel = d[0];
            #1;
            chk("reset_out_valid", {31'd0, m_out_valid}, 32'd0);
            chk("reset_out_last", {31'd0, m_out_last}, 32'd0);
            chk("reset_out_instr", m_out_instr, 32'd0);
            chk("reset_in_ready", {31'd0, m_in_ready}, 32'd0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            sel = vecs[i].sel;
            send($sformatf("v%0d", i), vecs[i].value, vecs[i].rt);
            expect_word($sformatf("v%0d_w0", i), vecs[i].w0, !vecs[i].pair, vecs[i].stall);
            if (vecs[i].pair) begin
                expect_word($sformatf("v%0d_w1", i), vecs[i].w1, 1'b1, vecs[i].stall);
            end
            expect_idle($sformatf("v%0d", i));
        end

`ifdef LI_ZERO_DROP_EN
        sel = 1'b0;
        send("zdrop", 32'hDEAD_BEEF, 5'd0);
        for (int i = 0; i < 4; i++) begin
            chk("zdrop_out_valid", {31'd0, m_out_valid}, 32'd0);
            chk("zdrop_in_ready", {31'd0, m_in_ready}, 32'd1);
            @(negedge clk);
        end
`endif

        sel = 1'b1;
        send("rst", 32'hFFFF_FFFC, 5'd1);
        expect_word("rst_w0", 32'h3C01FFFF, 1'b0, 0);
        chk("rst_pending_valid", {31'd0, m_out_valid}, 32'd1);
        chk("rst_pending_instr", m_out_instr, 32'h3421FFFC);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", {31'd0, m_out_valid}, 32'd0);
        chk("rst_mid_out_instr", m_out_instr, 32'd0);
        chk("rst_mid_out_last", {31'd0, m_out_last}, 32'd0);
        chk("rst_mid_in_ready", {31'd0, m_in_ready}, 32'd0);
        rst_n       = 1'b1;
        d_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_after_out_valid", {31'd0, m_out_valid}, 32'd0);
        end
        d_out_ready = 1'b0;

        sel = 1'b0;
        send("recover", 32'h0000_0001, 5'd1);
        expect_word("recover_w0", 32'h24010001, 1'b1, 0);
        expect_idle("recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
